// File: rtl/fpu_issue_sched_if.sv
// Request/response bundle between the two issuing lanes, the shared FPU datapath and the
// issue scheduler.
interface fpu_issue_sched_if #(
    parameter int unsigned TAG_W = 6
) ();
    logic               exHold;
    logic [1:0]         reqValid;
    logic [3:0]         reqOp;
    logic [2*TAG_W-1:0] reqTag;
    logic [1:0]         flush;
    logic [63:0]        fpuResult;
    logic [3:0]         fpuExOp;
    logic               fpuSelMul;
    logic               fpuBusy;
    logic [1:0]         laneHold;
    logic [1:0]         rspValid;
    logic [TAG_W-1:0]   rspTag;
    logic [63:0]        rspVal;

    modport master (
        output exHold, reqValid, reqOp, reqTag, flush, fpuResult,
        input  fpuExOp, fpuSelMul, fpuBusy, laneHold, rspValid, rspTag, rspVal
    );

    modport slave (
        input  exHold, reqValid, reqOp, reqTag, flush, fpuResult,
        output fpuExOp, fpuSelMul, fpuBusy, laneHold, rspValid, rspTag, rspVal
    );
endinterface

// File: rtl/fpu_issue_sched.sv
// Arbitrates one non-pipelined FPU datapath between two lanes, counts out the fixed
// per-class latency and returns the captured result with its tag to the owning lane.
module fpu_issue_sched #(
    parameter int unsigned ADD_LAT = 5,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned CVT_LAT = 6,
    parameter int unsigned TAG_W   = 6
) (
    input logic               clock,
    input logic               reset,
    fpu_issue_sched_if.slave  bus
);
    localparam int unsigned MaxAm = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned MaxLat = (MaxAm > CVT_LAT) ? MaxAm : CVT_LAT;
    localparam int unsigned CntW = (MaxLat > 2) ? $clog2(MaxLat) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpMul = 2'd2;
    localparam logic [1:0] OpCvt = 2'd3;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [1:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              last_q, last_d;
    logic [63:0]       rsp_val_q, rsp_val_d;

    logic [1:0]        elig;
    logic              grant;
    logic [1:0]        grant_op;
    logic [CntW-1:0]   lat_load;
    logic              owner_flush;
    logic              busy;
    logic [1:0]        rsp_valid;
    logic [CntW-1:0]   cnt_dec;

    always_comb begin
        elig        = bus.reqValid & ~bus.flush;
        // Alternate on contention; reset value of last_q makes lane 0 win first.
        grant       = (elig == 2'b11) ? ~last_q : elig[1];
        grant_op    = grant ? bus.reqOp[3:2] : bus.reqOp[1:0];
        owner_flush = bus.flush[owner_q];
        cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        unique case (grant_op)
            OpMul:   lat_load = CntW'(MUL_LAT - 1);
            OpCvt:   lat_load = CntW'(CVT_LAT - 1);
            default: lat_load = CntW'(ADD_LAT - 1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        op_d      = op_q;
        tag_d     = tag_q;
        last_d    = last_q;
        rsp_val_d = rsp_val_q;
        if (!bus.exHold) begin
            unique case (state_q)
                StIdle: begin
                    if (elig != 2'b00) begin
                        owner_d = grant;
                        op_d    = grant_op;
                        tag_d   = grant ? bus.reqTag[TAG_W +: TAG_W] : bus.reqTag[0 +: TAG_W];
                        last_d  = grant;
                        cnt_d   = lat_load;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    cnt_d = cnt_dec;
                    if (owner_flush) begin
                        state_d = StDrain;
                    end else if (cnt_q == '0) begin
                        rsp_val_d = bus.fpuResult;
                        state_d   = StDone;
                    end
                end
                StDrain: begin
                    // The datapath cannot be aborted; let it finish before releasing it.
                    cnt_d = cnt_dec;
                    if (cnt_q == '0) state_d = StIdle;
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            op_q      <= OpAdd;
            tag_q     <= '0;
            last_q    <= 1'b1;
            rsp_val_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            last_q    <= last_d;
            rsp_val_q <= rsp_val_d;
        end
    end

    always_comb begin
        busy      = (state_q == StRun) || (state_q == StDrain);
        rsp_valid = 2'b00;
        if ((state_q == StDone) && !bus.exHold && !owner_flush) rsp_valid[owner_q] = 1'b1;
    end

    always_comb begin
        bus.fpuExOp = 4'd0;
        if (busy) begin
            unique case (op_q)
                OpAdd:   bus.fpuExOp = 4'd1;
                OpSub:   bus.fpuExOp = 4'd2;
                OpCvt:   bus.fpuExOp = 4'd4;
                default: bus.fpuExOp = 4'd0;
            endcase
        end
        bus.fpuSelMul = busy && (op_q == OpMul);
        bus.fpuBusy   = busy;
        bus.rspValid  = rsp_valid;
        bus.laneHold  = bus.reqValid & ~bus.flush & ~rsp_valid;
        bus.rspTag    = tag_q;
        bus.rspVal    = rsp_val_q;
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed and randomized checks of fpu_issue_sched against an age-based transaction model.
module tb_fpu_issue_sched;
    localparam int unsigned ADD_LAT = 5;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned CVT_LAT = 6;
    localparam int unsigned TAG_W   = 6;

    logic clock = 1'b0;
    logic reset;

    fpu_issue_sched_if #(.TAG_W(TAG_W)) bus ();

    fpu_issue_sched #(
        .ADD_LAT(ADD_LAT),
        .MUL_LAT(MUL_LAT),
        .CVT_LAT(CVT_LAT),
        .TAG_W  (TAG_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobe_cyc [2];
    int strobe_cnt [2];
    logic [1:0] exp_rsp;

    // Model: an op in flight is tracked by its age in unheld cycles since grant.
    bit               m_active = 1'b0;
    bit               m_flushed, m_late;
    int               m_age, m_owner, m_last = 1;
    logic [1:0]       m_op = 2'd0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [63:0]      m_res = '0;

    function automatic int lat_of(logic [1:0] op);
        case (op)
            2'd2:    return MUL_LAT;
            2'd3:    return CVT_LAT;
            default: return ADD_LAT;
        endcase
    endfunction

    function automatic logic [3:0] code_of(logic [1:0] op);
        case (op)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd3:    return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        int         lat, g;
        bit         busy, done;
        logic [1:0] elig;
        @(negedge clock);
        lat     = lat_of(m_op);
        busy    = m_active && (m_age <= lat || m_late);
        done    = m_active && (m_age == lat + 1) && !m_flushed;
        exp_rsp = 2'b00;
        if (done && !bus.exHold && !bus.flush[m_owner]) exp_rsp[m_owner] = 1'b1;
        chk("busy", bus.fpuBusy, busy);
        chk("exop", bus.fpuExOp, busy ? code_of(m_op) : 4'd0);
        chk("selmul", bus.fpuSelMul, busy && m_op == 2'd2);
        chk("rspvalid", bus.rspValid, exp_rsp);
        chk("lanehold", bus.laneHold, bus.reqValid & ~bus.flush & ~exp_rsp);
        if (exp_rsp != 2'b00) begin
            chk("rsptag", bus.rspTag, m_tag);
            chk("rspval", bus.rspVal, m_res);
        end
        for (int l = 0; l < 2; l++) begin
            if (bus.rspValid[l] === 1'b1) begin
                strobe_cyc[l] = cyc;
                strobe_cnt[l]++;
            end
        end
        @(posedge clock);
        if (reset) begin
            m_active = 1'b0;
            m_last   = 1;
            m_res    = '0;
            m_tag    = '0;
            m_op     = 2'd0;
        end else if (!bus.exHold) begin
            if (!m_active) begin
                elig = bus.reqValid & ~bus.flush;
                if (elig != 2'b00) begin
                    g         = (elig == 2'b11) ? 1 - m_last : (elig[1] ? 1 : 0);
                    m_active  = 1'b1;
                    m_owner   = g;
                    m_age     = 1;
                    m_flushed = 1'b0;
                    m_late    = 1'b0;
                    m_op      = bus.reqOp[2*g +: 2];
                    m_tag     = bus.reqTag[g*TAG_W +: TAG_W];
                    m_last    = g;
                end
            end else if (m_age <= lat) begin
                if (bus.flush[m_owner] && !m_flushed) begin
                    m_flushed = 1'b1;
                    m_late    = (m_age == lat);
                end
                if (!m_flushed && m_age == lat) m_res = bus.fpuResult;
                m_age++;
                if (m_age > lat && m_flushed && !m_late) m_active = 1'b0;
            end else begin
                m_active = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    // One cycle as seen by the lanes: drop a request once served or flushed.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            for (int l = 0; l < 2; l++)
                if (exp_rsp[l] || bus.flush[l]) bus.reqValid[l] = 1'b0;
            bus.flush = 2'b00;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, bus.fpuBusy, 0);
        chk({tag, "_exop"}, bus.fpuExOp, 0);
        chk({tag, "_selmul"}, bus.fpuSelMul, 0);
        chk({tag, "_rspvalid"}, bus.rspValid, 0);
        chk({tag, "_rsptag"}, bus.rspTag, 0);
        chk({tag, "_rspval"}, bus.rspVal, 0);
        chk({tag, "_lanehold"}, bus.laneHold, 0);
    endtask

    task automatic req(input int l, input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bus.reqValid[l]            = 1'b1;
        bus.reqOp[2*l +: 2]        = op;
        bus.reqTag[l*TAG_W +: TAG_W] = tag;
    endtask

    task automatic clr_strobes();
        strobe_cyc[0] = -100;
        strobe_cyc[1] = -100;
        strobe_cnt[0] = 0;
        strobe_cnt[1] = 0;
    endtask

    initial begin
        int g;
        reset         = 1'b1;
        bus.exHold    = 1'b0;
        bus.reqValid  = 2'b00;
        bus.reqOp     = 4'd0;
        bus.reqTag    = '0;
        bus.flush     = 2'b00;
        bus.fpuResult = 64'd0;
        clr_strobes();
        tick(2);
        reset = 1'b0;
        chk_zero("reset");

        // Lane 0 ADD, plain latency.
        clr_strobes();
        bus.fpuResult = 64'h3FF8_0000_0000_0000;
        req(0, 2'd0, 6'h12);
        g = cyc;
        tick(10);
        chk("t1_lat", strobe_cyc[0] - g, 6);
        chk("t1_val", bus.rspVal, 64'h3FF8_0000_0000_0000);
        chk("t1_tag", bus.rspTag, 6'h12);

        // Both lanes MUL after reset: lane 0 first, lane 1 seven cycles later, twice.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            clr_strobes();
            bus.fpuResult = {$urandom, $urandom};
            req(0, 2'd2, 6'h21);
            req(1, 2'd2, 6'h22);
            g = cyc;
            tick(1);
            chk("t2_selmul", bus.fpuSelMul, 1);
            chk("t2_exop", bus.fpuExOp, 0);
            tick(16);
            chk("t2_lane0", strobe_cyc[0] - g, 6);
            chk("t2_lane1", strobe_cyc[1] - g, 13);
        end

        // Lane 0 CVT flushed in RUN cycle 2; waiting lane 1 ADD granted straight after.
        clr_strobes();
        req(0, 2'd3, 6'h31);
        req(1, 2'd0, 6'h32);
        g = cyc;
        tick(2);
        bus.flush[0] = 1'b1;
        tick(1);
        chk("t3_drain_busy", bus.fpuBusy, 1);
        tick(14);
        chk("t3_no_rsp0", strobe_cnt[0], 0);
        chk("t3_lane1", strobe_cyc[1] - g, 13);

        // Lane 1 SUB with a 3-cycle exHold mid-RUN.
        clr_strobes();
        req(1, 2'd1, 6'h05);
        g = cyc;
        tick(3);
        bus.exHold = 1'b1;
        tick(3);
        chk("t4_exop_held", bus.fpuExOp, 2);
        bus.exHold = 1'b0;
        tick(8);
        chk("t4_lat", strobe_cyc[1] - g, 9);

        // exHold over the DONE cycle delays a single strobe.
        clr_strobes();
        req(0, 2'd0, 6'h2A);
        g = cyc;
        tick(6);
        bus.exHold = 1'b1;
        tick(2);
        bus.exHold = 1'b0;
        tick(4);
        chk("t5_lat", strobe_cyc[0] - g, 8);
        chk("t5_count", strobe_cnt[0], 1);

        // Reset in RUN cycle 3 discards the op; lane 1 ADD then runs normally.
        clr_strobes();
        req(0, 2'd2, 6'h11);
        tick(3);
        bus.reqValid = 2'b00;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero("t6");
        req(1, 2'd0, 6'h07);
        g = cyc;
        tick(9);
        chk("t6_lat", strobe_cyc[1] - g, 6);
        chk("t6_no_rsp0", strobe_cnt[0], 0);

        // Randomized traffic with flushes and holds.
        for (int n = 0; n < 2500; n++) begin
            for (int l = 0; l < 2; l++) begin
                if (!bus.reqValid[l] && $urandom_range(0, 3) == 0)
                    req(l, 2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 63)));
                bus.flush[l] = ($urandom_range(0, 24) == 0);
            end
            bus.exHold    = ($urandom_range(0, 5) == 0);
            bus.fpuResult = {$urandom, $urandom};
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
